// File: rtl/sdram_bist.sv
// SDRAM built-in self-test master: writes a pattern over [addr_start, addr_end], reads it back and compares.
// Define SDRAM_BIST_LFSR_EN to build the 16-bit LFSR pattern generator selected by pattern_sel.
`timescale 1ns/1ps
module sdram_bist #(
    parameter int AW = 23,
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   addr_start,
    input  logic [AW-1:0]   addr_end,
    input  logic            pattern_sel,
    input  logic [DW-1:0]   seed,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            cfg_err,
    output logic [15:0]     err_count,
    output logic [AW-1:0]   first_err_addr,
    output logic            bus_read,
    output logic            bus_write,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    output logic [DW/8-1:0] bus_byteenable,
    input  logic            bus_ready,
    input  logic            bus_rvalid,
    input  logic [DW-1:0]   bus_rdata
);
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_WAIT_RD, S_DONE} state_t;

    state_t        r_state;
    logic [AW-1:0] r_addr_start, r_addr_end, r_first_err_addr, r_bus_addr;
    logic [DW-1:0] r_seed, r_pat, r_bus_wdata;
    logic [15:0]   r_err_count;
    logic          r_busy, r_done, r_pass, r_cfg_err, r_bus_read, r_bus_write;

    logic [AW-1:0] w_addr_inc;
    logic [DW-1:0] w_addr_pat, w_next_pat, w_seed_eff;
    logic          w_addr_last, w_mismatch;

    assign w_addr_inc  = r_bus_addr + AW'(1);
    assign w_addr_pat  = DW'(w_addr_inc);
    // Compared before incrementing, so addr_end at the top of the space never wraps.
    assign w_addr_last = (r_bus_addr == r_addr_end);
    assign w_mismatch  = (bus_rdata != r_pat);

`ifdef SDRAM_BIST_LFSR_EN
    logic r_mode;

    assign w_seed_eff = (pattern_sel && seed == '0) ? DW'(1) : seed;

    always_comb begin
        w_next_pat = w_addr_pat ^ r_seed;
        if (r_mode)
            w_next_pat = {r_pat[14:0], r_pat[15] ^ r_pat[13] ^ r_pat[12] ^ r_pat[10]};
    end
`else
    logic w_unused_sel;

    assign w_unused_sel = pattern_sel;
    assign w_seed_eff   = seed;
    assign w_next_pat   = w_addr_pat ^ r_seed;
`endif

    // NOTE: sequential state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_addr_start     <= '0;
            r_addr_end       <= '0;
            r_seed           <= '0;
            r_pat            <= '0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_cfg_err        <= 1'b0;
            r_bus_read       <= 1'b0;
            r_bus_write      <= 1'b0;
            r_bus_addr       <= '0;
            r_bus_wdata      <= '0;
`ifdef SDRAM_BIST_LFSR_EN
            r_mode           <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_addr_start     <= addr_start;
                        r_addr_end       <= addr_end;
                        r_seed           <= w_seed_eff;
                        r_pat            <= w_seed_eff;
                        r_err_count      <= '0;
                        r_first_err_addr <= '0;
                        r_pass           <= 1'b0;
                        r_bus_addr       <= addr_start;
                        r_bus_wdata      <= w_seed_eff;
`ifdef SDRAM_BIST_LFSR_EN
                        r_mode           <= pattern_sel;
`endif
                        if (addr_start > addr_end) begin
                            r_cfg_err <= 1'b1;
                            r_done    <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= S_DONE;
                        end else begin
                            r_cfg_err   <= 1'b0;
                            r_done      <= 1'b0;
                            r_busy      <= 1'b1;
                            r_bus_write <= 1'b1;
                            r_state     <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus_ready) begin
                        if (w_addr_last) begin
                            r_bus_write <= 1'b0;
                            r_bus_read  <= 1'b1;
                            r_bus_addr  <= r_addr_start;
                            r_pat       <= r_seed;
                            r_state     <= S_READ;
                        end else begin
                            r_bus_addr  <= w_addr_inc;
                            r_pat       <= w_next_pat;
                            r_bus_wdata <= w_next_pat;
                        end
                    end
                end
                S_READ: begin
                    if (bus_ready) begin
                        r_bus_read <= 1'b0;
                        r_state    <= S_WAIT_RD;
                    end
                end
                S_WAIT_RD: begin
                    if (bus_rvalid) begin
                        if (w_mismatch) begin
                            if (r_err_count != 16'hFFFF)
                                r_err_count <= r_err_count + 16'd1;
                            if (r_err_count == '0)
                                r_first_err_addr <= r_bus_addr;
                        end
                        if (w_addr_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (r_err_count == '0) && !w_mismatch;
                            r_state <= S_DONE;
                        end else begin
                            r_bus_addr <= w_addr_inc;
                            r_pat      <= w_next_pat;
                            r_bus_read <= 1'b1;
                            r_state    <= S_READ;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign cfg_err        = r_cfg_err;
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err_addr;
    assign bus_read       = r_bus_read;
    assign bus_write      = r_bus_write;
    assign bus_addr       = r_bus_addr;
    assign bus_wdata      = r_bus_wdata;
    assign bus_byteenable = '1;
endmodule

// File: tb/tb_sdram_bist.sv
// Directed bench for sdram_bist: SDRAM bus model with fixed read latency, optional stalls and one corrupted word.
`timescale 1ns/1ps
module tb_sdram_bist;
    localparam int AW = 23;
    localparam int DW = 16;
    localparam logic [AW-1:0] TOP = '1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [AW-1:0]   addr_start = '0;
    logic [AW-1:0]   addr_end = '0;
    logic            pattern_sel = 1'b0;
    logic [DW-1:0]   seed = '0;
    logic            busy, done, pass, cfg_err;
    logic [15:0]     err_count;
    logic [AW-1:0]   first_err_addr;
    logic            bus_read, bus_write;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_wdata;
    logic [DW/8-1:0] bus_byteenable;
    logic            bus_ready = 1'b1;
    logic            bus_rvalid = 1'b0;
    logic [DW-1:0]   bus_rdata = '0;

    int n_checks = 0;
    int n_fail = 0;

    sdram_bist #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .addr_start(addr_start), .addr_end(addr_end),
        .pattern_sel(pattern_sel), .seed(seed), .busy(busy), .done(done), .pass(pass),
        .cfg_err(cfg_err), .err_count(err_count), .first_err_addr(first_err_addr),
        .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_byteenable(bus_byteenable), .bus_ready(bus_ready), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Bus model: decides ready at the negedge, read data returns two cycles after accept.
    logic [15:0]   mem [logic [AW-1:0]];
    bit            stall_en = 0, corrupt_en = 0, prev_stall = 0;
    int            wr_cnt = 0, rd_acc = 0, zero_acc = 0, overlap = 0, stab_err = 0, lat_cnt = 0;
    logic [AW-1:0] rd_addr = '0, prev_addr = '0;
    logic [DW-1:0] prev_wdata = '0;
    logic [1:0]    prev_req = '0;

    always @(negedge clk) begin
        bus_rvalid = 1'b0;
        if (rst) begin
            lat_cnt    = 0;
            prev_stall = 0;
            bus_ready  = 1'b1;
        end else begin
            if (prev_stall && (bus_addr !== prev_addr || bus_wdata !== prev_wdata ||
                               {bus_read, bus_write} !== prev_req))
                stab_err++;
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = (corrupt_en && rd_addr == AW'(5)) ? 16'hFFFF : mem[rd_addr];
                end
            end
            bus_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if ((bus_read || bus_write) && bus_ready) begin
                if (bus_addr == '0) zero_acc++;
                if (bus_write) begin
                    mem[bus_addr] = bus_wdata;
                    wr_cnt++;
                end else begin
                    if (lat_cnt != 0) overlap++;
                    rd_acc++;
                    rd_addr = bus_addr;
                    lat_cnt = 2;
                end
            end
            prev_stall = (bus_read || bus_write) && !bus_ready;
            prev_addr  = bus_addr;
            prev_wdata = bus_wdata;
            prev_req   = {bus_read, bus_write};
        end
    end

    int            cyc;
    logic          c1_busy, c1_write, c1_done;
    logic [AW-1:0] c1_addr;

    task automatic run(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic ps,
                       input logic [DW-1:0] sd, input bit stall, input bit corrupt);
        stall_en = stall; corrupt_en = corrupt;
        wr_cnt = 0; rd_acc = 0; zero_acc = 0; overlap = 0; stab_err = 0;
        addr_start = a0; addr_end = a1; pattern_sel = ps; seed = sd; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        c1_busy = busy; c1_write = bus_write; c1_done = done; c1_addr = bus_addr;
        cyc = 0;
        while (!done && cyc < 4000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check("run_done", 32'(done), 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);
        check("rst_err_count", 32'(err_count), 0);
        check("rst_first_err", 32'(first_err_addr), 0);
        check("rst_bus_read", 32'(bus_read), 0);
        check("rst_bus_write", 32'(bus_write), 0);
        check("rst_bus_addr", 32'(bus_addr), 0);
        check("rst_bus_wdata", 32'(bus_wdata), 0);
        check("rst_byteen", 32'(bus_byteenable), 32'h3);
        rst = 1'b0;
        @(negedge clk);

        // Address pattern 0..7, no stalls: 8 writes at one per cycle, 8 reads at 3 cycles each.
        run(AW'(0), AW'(7), 1'b0, 16'h0000, 0, 0);
        check("r1_c1_busy", 32'(c1_busy), 1);
        check("r1_c1_write", 32'(c1_write), 1);
        check("r1_c1_addr", 32'(c1_addr), 0);
        check("r1_cycles", 32'(cyc), 32);
        check("r1_pass", 32'(pass), 1);
        check("r1_err_count", 32'(err_count), 0);
        check("r1_writes", 32'(wr_cnt), 8);
        check("r1_reads", 32'(rd_acc), 8);
        check("r1_mem5", 32'(mem[AW'(5)]), 5);
        check("r1_mem7", 32'(mem[AW'(7)]), 7);
        check("r1_busy_end", 32'(busy), 0);

        // Same run with address 5 reading back as FFFF.
        run(AW'(0), AW'(7), 1'b0, 16'h0000, 0, 1);
        check("r2_err_count", 32'(err_count), 1);
        check("r2_first_err", 32'(first_err_addr), 5);
        check("r2_pass", 32'(pass), 0);

        // Random stalls on bus_ready.
        run(AW'(0), AW'(7), 1'b0, 16'h0000, 1, 0);
        check("r3_pass", 32'(pass), 1);
        check("r3_err_count", 32'(err_count), 0);
        check("r3_first_err", 32'(first_err_addr), 0);
        check("r3_stable", 32'(stab_err), 0);
        check("r3_overlap", 32'(overlap), 0);
        check("r3_writes", 32'(wr_cnt), 8);
        check("r3_reads", 32'(rd_acc), 8);

        // Inverted range: immediate done with cfg_err and no bus traffic.
        run(AW'(10), AW'(3), 1'b0, 16'h0000, 0, 0);
        repeat (4) @(negedge clk);
        check("r4_c1_done", 32'(c1_done), 1);
        check("r4_c1_busy", 32'(c1_busy), 0);
        check("r4_cfg_err", 32'(cfg_err), 1);
        check("r4_pass", 32'(pass), 0);
        check("r4_accesses", 32'(wr_cnt + rd_acc), 0);

        // Top of the address space, pattern_sel=1, seed ACE1.
        run(TOP - AW'(3), TOP, 1'b1, 16'hACE1, 0, 0);
        check("r5_writes", 32'(wr_cnt), 4);
        check("r5_reads", 32'(rd_acc), 4);
        check("r5_zero_access", 32'(zero_acc), 0);
        check("r5_pass", 32'(pass), 1);
        check("r5_cfg_err", 32'(cfg_err), 0);
        check("r5_word0", 32'(mem[TOP - AW'(3)]), 32'hACE1);
`ifdef SDRAM_BIST_LFSR_EN
        check("r5_word1", 32'(mem[TOP - AW'(2)]), 32'h59C3);
`else
        check("r5_word1", 32'(mem[TOP - AW'(2)]), 32'h531C);
`endif

        // Reset during the write phase, then a clean run.
        stall_en = 0; corrupt_en = 0;
        addr_start = AW'(0); addr_end = AW'(7); pattern_sel = 1'b0; seed = 16'h0000; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("r6_mid_write", 32'(bus_write), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("r6_rst_write", 32'(bus_write), 0);
        check("r6_rst_busy", 32'(busy), 0);
        check("r6_rst_err", 32'(err_count), 0);
        rst = 1'b0;
        @(negedge clk);
        run(AW'(0), AW'(7), 1'b0, 16'h0000, 0, 0);
        check("r6_pass", 32'(pass), 1);
        check("r6_reads", 32'(rd_acc), 8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
